// File: rtl/grid_reader_if.sv
// rtl/grid_reader_if.sv - row stream bundle between grid_reader and its sink
interface grid_reader_if;
    logic [7:0] row_data;
    logic [2:0] row_idx;
    logic       row_valid;
    logic       row_ready;

    modport master (
        output row_data,
        output row_idx,
        output row_valid,
        input  row_ready
    );

    modport slave (
        input  row_data,
        input  row_idx,
        input  row_valid,
        output row_ready
    );
endinterface

// File: rtl/grid_reader.sv
// rtl/grid_reader.sv - snapshots an 8x8 grid and streams it row by row
// Optional macro GRID_READER_POPCOUNT_EN adds a live-cell count of each snapshot.
module grid_reader #(
    parameter int ROW_GAP = 0
) (
    input  logic                 clk,
    input  logic                 _rst,
    input  logic [63:0]          grid_in,
    input  logic                 snap_req,
    output logic                 busy,
    grid_reader_if.master        row,
    output logic                 frame_done,
    output logic [6:0]           pop_count
);
    typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

    localparam logic [3:0] GAP_LAST = 4'(ROW_GAP - 1);

    state_t      state, state_next;
    logic [63:0] snapshot;
    logic [2:0]  idx, idx_next;
    logic [3:0]  gap_cnt, gap_next;
    logic        capture;

    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            state    <= IDLE;
            snapshot <= '0;
            idx      <= '0;
            gap_cnt  <= '0;
        end else begin
            state   <= state_next;
            idx     <= idx_next;
            gap_cnt <= gap_next;
            if (capture) begin
                snapshot <= grid_in;
            end
        end
    end

    always_comb begin
        state_next = state;
        idx_next   = idx;
        gap_next   = gap_cnt;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (snap_req) begin
                    capture    = 1'b1;
                    idx_next   = '0;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (row.row_ready) begin
                    // row_idx parks at 7 after the last row until the next capture
                    if (idx == 3'd7) begin
                        state_next = DONE;
                    end else begin
                        idx_next = idx + 3'd1;
                        if (ROW_GAP != 0) begin
                            state_next = GAP;
                            gap_next   = '0;
                        end
                    end
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_next = SEND;
                    gap_next   = '0;
                end else begin
                    gap_next = gap_cnt + 4'd1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy          = (state != IDLE);
    assign frame_done    = (state == DONE);
    assign row.row_valid = (state == SEND);
    assign row.row_idx   = idx;
    assign row.row_data  = snapshot[{idx, 3'b000} +: 8];

`ifdef GRID_READER_POPCOUNT_EN
    logic [6:0] ones;
    logic [6:0] pop_reg;

    always_comb begin
        ones = '0;
        for (int i = 0; i < 64; i++) begin
            ones = ones + 7'(grid_in[i]);
        end
    end

    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            pop_reg <= '0;
        end else if (capture) begin
            pop_reg <= ones;
        end
    end

    assign pop_count = pop_reg;
`else
    assign pop_count = '0;
`endif
endmodule

// File: tb/tb_grid_reader.sv
// tb/tb_grid_reader.sv - randomized bench for grid_reader with ROW_GAP 0 and 3 instances
module tb_grid_reader;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [63:0] grid[2];
    logic        snap[2];
    logic        ready[2];
    logic        busy_o[2];
    logic        fd_o[2];
    logic [6:0]  pop_o[2];
    logic        v_o[2];
    logic [2:0]  i_o[2];
    logic [7:0]  d_o[2];

    grid_reader_if if0();
    grid_reader_if if3();

    assign if0.row_ready = ready[0];
    assign if3.row_ready = ready[1];
    assign v_o[0] = if0.row_valid;
    assign i_o[0] = if0.row_idx;
    assign d_o[0] = if0.row_data;
    assign v_o[1] = if3.row_valid;
    assign i_o[1] = if3.row_idx;
    assign d_o[1] = if3.row_data;

    grid_reader #(.ROW_GAP(0)) dut0 (
        .clk(clk), ._rst(rst_n), .grid_in(grid[0]), .snap_req(snap[0]),
        .busy(busy_o[0]), .row(if0), .frame_done(fd_o[0]), .pop_count(pop_o[0])
    );

    grid_reader #(.ROW_GAP(3)) dut3 (
        .clk(clk), ._rst(rst_n), .grid_in(grid[1]), .snap_req(snap[1]),
        .busy(busy_o[1]), .row(if3), .frame_done(fd_o[1]), .pop_count(pop_o[1])
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: one frame as a list of rows plus the pending idle gap
    bit          active[2];
    bit          done_pend[2];
    logic [63:0] snapm[2];
    logic [6:0]  popm[2];
    int          nxt[2];
    int          low_left[2];
    int          last_idx[2];
    int          fcount[2];
    int          stall[2];
    int          ndone[2];
    int          rcd = 0;
    bit          rst_fired = 0;

    task automatic check(input string tag, input int k, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d] at %0t: got %0h expected %0h", tag, k, $time, obs, exp);
        end
    endtask

    function automatic int gap_of(input int k);
        return (k == 0) ? 0 : 3;
    endfunction

    function automatic logic [6:0] pop_exp(input logic [63:0] g);
`ifdef GRID_READER_POPCOUNT_EN
        return 7'($countones(g));
`else
        return 7'd0;
`endif
    endfunction

    function automatic logic [63:0] directed_grid(input int fc);
        case (fc)
            0: return 64'h0000_0000_0000_0007;
            1: return 64'h0102_0408_1020_4080;
            default: return 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

    task automatic model_reset(input int k);
        if (active[k]) fcount[k]++;
        active[k]    = 0;
        done_pend[k] = 0;
        nxt[k]       = 0;
        low_left[k]  = 0;
        last_idx[k]  = 0;
        popm[k]      = '0;
    endtask

    task automatic check_zero(input int k);
        check("rst_valid", k, v_o[k], 0);
        check("rst_busy", k, busy_o[k], 0);
        check("rst_done", k, fd_o[k], 0);
        check("rst_idx", k, i_o[k], 0);
        check("rst_data", k, d_o[k], 0);
        check("rst_pop", k, pop_o[k], 0);
    endtask

    task automatic check_inst(input int k);
        logic [63:0] rowv;
        if (!active[k]) begin
            check("idle_valid", k, v_o[k], 0);
            check("idle_busy", k, busy_o[k], 0);
            check("idle_done", k, fd_o[k], 0);
            check("idle_idx", k, i_o[k], last_idx[k]);
        end else if (done_pend[k]) begin
            check("done_pulse", k, fd_o[k], 1);
            check("done_busy", k, busy_o[k], 1);
            check("done_valid", k, v_o[k], 0);
            check("done_idx", k, i_o[k], 7);
        end else if (low_left[k] > 0) begin
            check("gap_valid", k, v_o[k], 0);
            check("gap_busy", k, busy_o[k], 1);
            check("gap_done", k, fd_o[k], 0);
            check("gap_idx", k, i_o[k], nxt[k]);
        end else begin
            rowv = snapm[k] >> (nxt[k] * 8);
            check("send_valid", k, v_o[k], 1);
            check("send_busy", k, busy_o[k], 1);
            check("send_done", k, fd_o[k], 0);
            check("send_idx", k, i_o[k], nxt[k]);
            check("send_data", k, d_o[k], rowv[7:0]);
        end
        check("pop", k, pop_o[k], popm[k]);
    endtask

    task automatic drive(input int k);
        int fc;
        fc = fcount[k];
        grid[k]  = {$urandom, $urandom};
        snap[k]  = 1'b0;
        ready[k] = 1'b1;
        if (!active[k]) begin
            if (fc < 3) begin
                snap[k] = 1'b1;
                grid[k] = directed_grid(fc);
            end else if (fc == 3) begin
                snap[k] = 1'b1;
            end else begin
                snap[k]  = ($urandom_range(0, 2) == 0);
                ready[k] = ($urandom_range(0, 1) == 0);
            end
        end else begin
            if (fc == 2) begin
                snap[k] = 1'b1;
                grid[k] = '0;
            end else begin
                snap[k] = ($urandom_range(0, 3) == 0);
            end
            if (fc == 1 && !done_pend[k] && low_left[k] == 0 && nxt[k] == 2 && stall[k] < 3) begin
                ready[k] = 1'b0;
                stall[k]++;
            end else if (fc > 3) begin
                ready[k] = ($urandom_range(0, 3) != 0);
            end
        end
    endtask

    task automatic advance(input int k);
        if (!active[k]) begin
            if (snap[k]) begin
                active[k]    = 1;
                snapm[k]     = grid[k];
                nxt[k]       = 0;
                low_left[k]  = 0;
                done_pend[k] = 0;
                stall[k]     = 0;
                popm[k]      = pop_exp(grid[k]);
            end
        end else if (done_pend[k]) begin
            active[k]    = 0;
            done_pend[k] = 0;
            last_idx[k]  = 7;
            ndone[k]++;
            fcount[k]++;
        end else if (low_left[k] > 0) begin
            low_left[k]--;
        end else if (ready[k]) begin
            if (nxt[k] == 7) begin
                done_pend[k] = 1;
            end else begin
                nxt[k]++;
                low_left[k] = gap_of(k);
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            grid[k]   = '0;
            snap[k]   = 1'b0;
            ready[k]  = 1'b1;
            snapm[k]  = '0;
            active[k] = 0;
            fcount[k] = 0;
            stall[k]  = 0;
            ndone[k]  = 0;
            model_reset(k);
        end
        repeat (3) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) check_zero(k);
        end
        rst_n = 1'b1;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (!rst_n) check_zero(k);
                else check_inst(k);
            end
            if (rcd > 0) begin
                rcd--;
                if (rcd == 0) rst_n = 1'b1;
                for (int k = 0; k < 2; k++) snap[k] = 1'b0;
                continue;
            end
            if (!rst_fired && fcount[0] == 3 && active[0] && !done_pend[0] &&
                low_left[0] == 0 && nxt[0] == 4) begin
                rst_fired = 1;
                rst_n     = 1'b0;
                rcd       = 2;
                for (int k = 0; k < 2; k++) begin
                    model_reset(k);
                    snap[k] = 1'b0;
                end
                continue;
            end
            for (int k = 0; k < 2; k++) begin
                drive(k);
                advance(k);
            end
        end

        check("reset_hit", 0, rst_fired, 1);
        for (int k = 0; k < 2; k++) check("frames", k, (ndone[k] >= 4), 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/grid_reader.md
GRID_READER -- requirements
Module: grid_reader

Interface
REQ-001 SHALL have parameter ROW_GAP, default 0: idle cycles inserted between consecutive row transfers (0..15).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port _rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port grid_in  input  64  live grid, row-major: bit r*8+c is cell (row r, column c).
REQ-005 SHALL have port snap_req  input  1  request to capture grid_in and stream it out.
REQ-006 SHALL have port busy  output  1  high from the capture edge until the frame completes.
REQ-007 SHALL have port row_data  output  8  captured row; bit c is column c.
REQ-008 SHALL have port row_idx  output  3  index of the row on row_data.
REQ-009 SHALL have port row_valid  output  1  row_data and row_idx are valid.
REQ-010 SHALL have port row_ready  input  1  sink accepts the row.
REQ-011 SHALL have port frame_done  output  1  one-cycle pulse after row 7 transfers.
REQ-012 SHALL have port pop_count  output  7  count of live cells in the last snapshot (0..64).

Function
REQ-013 SHALL implement states IDLE, SEND, GAP and DONE.
REQ-014 In IDLE, with snap_req=1 at a clock edge, SHALL load grid_in into a 64-bit snapshot register, set row_idx=0, set busy=1, and enter SEND.
REQ-015 In SEND, SHALL drive row_valid=1 with row_data = snapshot bits [row_idx*8+7 : row_idx*8].
REQ-016 A transfer SHALL occur on an edge where row_valid=1 and row_ready=1.
REQ-017 While row_valid=1 and row_ready=0, SHALL hold row_data and row_idx stable.
REQ-018 On a transfer with row_idx<7, SHALL increment row_idx; it SHALL stay in SEND if ROW_GAP=0, or enter GAP otherwise.
REQ-019 On a transfer with row_idx=7, SHALL enter DONE; row_idx SHALL NOT wrap to 0 until the next capture.
REQ-020 In GAP, SHALL drive row_valid=0 for exactly ROW_GAP cycles, then return to SEND.
REQ-021 In DONE, SHALL assert frame_done=1 and busy=1 for one cycle, then enter IDLE with busy=0.
REQ-022 SHALL ignore snap_req while busy=1; the request SHALL NOT be queued.
REQ-023 A snap_req in the DONE cycle SHALL be ignored; a snap_req in the first IDLE cycle after DONE SHALL be accepted.
REQ-024 Changes on grid_in after the capture edge SHALL NOT affect the frame being streamed.
REQ-025 With ROW_GAP=0 and row_ready held at 1, a frame SHALL take 8 SEND cycles plus 1 DONE cycle after the capture edge.

Reset
REQ-026 While _rst=0, SHALL force IDLE, with snapshot=0, row_idx=0, row_valid=0, busy=0, frame_done=0, pop_count=0, and the gap counter at 0.
REQ-027 Reset asserted mid-frame SHALL abort the frame immediately, with no frame_done pulse.
REQ-028 After _rst rises, the first capture SHALL need a new snap_req.

Configuration
REQ-029 With macro GRID_READER_POPCOUNT_EN defined, pop_count SHALL load the popcount of grid_in on the capture edge and hold it until the next capture.
REQ-030 Without GRID_READER_POPCOUNT_EN, pop_count SHALL be constant 0 and no popcount logic SHALL be built.

Verification
REQ-031 Capture with grid_in=64'h0000_0000_0000_0007 (row 0 = 8'h07), ROW_GAP=0, row_ready=1 -> rows 0..7 on consecutive cycles with data 07,00,00,00,00,00,00,00; frame_done high on cycle 9; busy low on cycle 10.
REQ-032 Capture 64'h0102_0408_1020_4080, row_ready low for 3 cycles on row 2 -> row_idx=2 and row_data=8'h20 held for 4 cycles; then rows 3..7 in order.
REQ-033 Capture 64'hFFFF_FFFF_FFFF_FFFF, then set grid_in=0 and pulse snap_req during the frame -> all 8 rows = FF, the extra request ignored, exactly one frame_done; pop_count=64 with the macro, 0 without.
REQ-034 ROW_GAP=3, row_ready=1 -> row_valid pattern 1,0,0,0,1,... with exactly 3 low cycles between each of the 8 transfers.
REQ-035 Reset pulsed while row_idx=4 -> all outputs 0 during reset; no frame_done; the next snap_req starts again at row_idx=0.
